clock_div_gen: RTL

Parametrised multi-channel clock-enable/divided-clock generator, the synthesizable successor to the behavioural testbench clock source. From one system clock it produces `NCH` independent divided clock waveforms, each with a programmable period and high time. Each channel also produces a one-cycle end-of-period tick. Configuration changes are glitch-free: they apply only at a period boundary or while the channel is idle. The block drives DLX3 peripheral timing (bus strobes, baud/timer enables) and testbench stimulus.

---
 rtl/clock_div_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/clock_div_gen.sv
// Multi-channel programmable clock divider. Each channel produces a divided clock
// and an end-of-period tick. Reconfiguration is double-buffered and applied only at a period wrap or while idle.
module clock_div_gen #(
   parameter int NCH         = 2,
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4,
   parameter int CHW         = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CHW-1:0]   cfg_ch,
   input  logic [WIDTH-1:0] cfg_div,
   input  logic [WIDTH-1:0] cfg_high,
   output logic [NCH-1:0]   clk_out,
   output logic [NCH-1:0]   tick
);

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
   localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_DIV / 2);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   logic [WIDTH-1:0] div_clamp;
   logic [WIDTH-1:0] high_clamp;
   logic [NCH-1:0]   ch_hit;
   logic [NCH-1:0]   pending_vec;

   // Clamp once for all channels so both phases of every period are at least one cycle.
   always_comb begin
      div_clamp  = (cfg_div < TWO) ? TWO : cfg_div;
      high_clamp = cfg_high;
      if (cfg_high < ONE) begin
         high_clamp = ONE;
      end else if (cfg_high > (div_clamp - ONE)) begin
         high_clamp = div_clamp - ONE;
      end
   end

   // An out-of-range channel index matches no channel, so it reads as ready and the write is dropped.
   assign cfg_ready = ~|(ch_hit & pending_vec);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      state_t           state_q, state_d;
      logic [WIDTH-1:0] div_act_q, div_act_d;
      logic [WIDTH-1:0] high_act_q, high_act_d;
      logic [WIDTH-1:0] div_sh_q, div_sh_d;
      logic [WIDTH-1:0] high_sh_q, high_sh_d;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic             pending_q, pending_d;
      logic             clk_out_q, clk_out_d;
      logic             tick_q, tick_d;
      logic             wr;
      logic             wrap;
      logic             commit;
      logic [WIDTH-1:0] div_eff;
      logic [WIDTH-1:0] high_eff;
      logic [WIDTH-1:0] cnt_n;

      assign ch_hit[gi]      = (cfg_ch == CHW'(gi));
      assign pending_vec[gi] = pending_q;
      assign clk_out[gi]     = clk_out_q;
      assign tick[gi]        = tick_q;

      always_comb begin
         state_d    = state_q;
         div_act_d  = div_act_q;
         high_act_d = high_act_q;
         div_sh_d   = div_sh_q;
         high_sh_d  = high_sh_q;
         cnt_d      = cnt_q;
         pending_d  = pending_q;
         clk_out_d  = clk_out_q;
         tick_d     = tick_q;

         wr     = cfg_valid & ch_hit[gi] & ~pending_q;
         wrap   = (state_q == ST_RUN) && (cnt_q == (div_act_q - ONE));
         commit = pending_q & ((state_q == ST_IDLE) | wrap);

         // The committed values already govern the period that starts on this edge.
         div_eff  = commit ? div_sh_q : div_act_q;
         high_eff = commit ? high_sh_q : high_act_q;
         cnt_n    = wrap ? '0 : (cnt_q + ONE);

         if (commit) begin
            div_act_d  = div_sh_q;
            high_act_d = high_sh_q;
            pending_d  = 1'b0;
         end
         if (wr) begin
            div_sh_d  = div_clamp;
            high_sh_d = high_clamp;
            pending_d = 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               cnt_d     = '0;
               clk_out_d = 1'b0;
               tick_d    = 1'b0;
               if (en[gi]) begin
                  state_d   = ST_RUN;
                  clk_out_d = 1'b1;
                  tick_d    = (div_act_q == ONE);
               end
            end
            ST_RUN: begin
               if (!en[gi]) begin
                  state_d   = ST_IDLE;
                  cnt_d     = '0;
                  clk_out_d = 1'b0;
                  tick_d    = 1'b0;
               end else begin
                  cnt_d     = cnt_n;
                  clk_out_d = (cnt_n < high_eff);
                  tick_d    = (cnt_n == (div_eff - ONE));
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q    <= ST_IDLE;
            div_act_q  <= DIV_RST;
            high_act_q <= HIGH_RST;
            div_sh_q   <= DIV_RST;
            high_sh_q  <= HIGH_RST;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
         end else begin
            state_q    <= state_d;
            div_act_q  <= div_act_d;
            high_act_q <= high_act_d;
            div_sh_q   <= div_sh_d;
            high_sh_q  <= high_sh_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
         end
      end
   end

endmodule
